// File: rtl/time_set_ctrl.sv
// Time-setting controller for the Nexys A7 clock: edits a private copy of hh:mm:ss,
// commits it through a one-cycle load pulse, and formats the eight display digit bytes.
module time_set_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       mode_i,
  input  logic [5:0] run_sec_i,
  input  logic [5:0] run_min_i,
  input  logic [4:0] run_hour_i,
  output logic       setting_o,
  output logic       load_o,
  output logic [5:0] load_sec_o,
  output logic [5:0] load_min_o,
  output logic [4:0] load_hour_o,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [7:0] d4,
  output logic [7:0] d5,
  output logic [7:0] d6,
  output logic [7:0] d7,
  output logic [7:0] d8
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  state_t     state, state_nx;
  logic       prev_inc, prev_dec, prev_mode;
  logic       rise_inc, rise_dec, rise_mode, step_ok;
  logic [4:0] edit_hour, hour_nx;
  logic [5:0] edit_min, min_nx, edit_sec, sec_nx;
  logic       edit_ok, commit;
  logic [CNT_W-1:0] blink_cnt;
  logic       blink_off;
  logic [5:0] src_hour, src_min, src_sec;
  logic       hide_h, hide_m, hide_s;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v >= top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  function automatic logic [5:0] sat(input logic [5:0] v, input logic [5:0] top);
    return (v > top) ? top : v;
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [7:0] digit_byte(input logic [3:0] bcd, input logic hide);
    return hide ? 8'h00 : {1'b1, 2'b00, bcd, 1'b0};
  endfunction

  assign rise_inc  = inc_i  & ~prev_inc;
  assign rise_dec  = dec_i  & ~prev_dec;
  assign rise_mode = mode_i & ~prev_mode;
  assign step_ok   = rise_inc ^ rise_dec;

  always_comb begin
    state_nx = state;
    hour_nx  = edit_hour;
    min_nx   = edit_min;
    sec_nx   = edit_sec;
    edit_ok  = 1'b0;
    commit   = 1'b0;
    case (state)
      RUN: if (rise_mode) begin
        state_nx = SET_H;
        hour_nx  = 5'(sat({1'b0, run_hour_i}, 6'd23));
        min_nx   = sat(run_min_i, 6'd59);
        sec_nx   = sat(run_sec_i, 6'd59);
      end
      SET_H: if (rise_mode) state_nx = SET_M;
        else if (step_ok) begin
          edit_ok = 1'b1;
          hour_nx = 5'(wrap_step({1'b0, edit_hour}, 6'd23, rise_inc));
        end
      SET_M: if (rise_mode) state_nx = SET_S;
        else if (step_ok) begin
          edit_ok = 1'b1;
          min_nx  = wrap_step(edit_min, 6'd59, rise_inc);
        end
      SET_S: if (rise_mode) begin
          state_nx = RUN;
          commit   = 1'b1;
        end else if (step_ok) begin
          edit_ok = 1'b1;
          sec_nx  = wrap_step(edit_sec, 6'd59, rise_inc);
        end
      default: state_nx = RUN;
    endcase
  end

  // Display source: live time while running, the edit copy while setting
  assign src_hour = (state == RUN) ? {1'b0, run_hour_i} : {1'b0, edit_hour};
  assign src_min  = (state == RUN) ? run_min_i : edit_min;
  assign src_sec  = (state == RUN) ? run_sec_i : edit_sec;
  assign hide_h   = blink_off & (state == SET_H);
  assign hide_m   = blink_off & (state == SET_M);
  assign hide_s   = blink_off & (state == SET_S);

  always_ff @(posedge clk_100MHz_i) begin
    if (!reset_i) begin
      state       <= RUN;
      prev_inc    <= 1'b1;
      prev_dec    <= 1'b1;
      prev_mode   <= 1'b1;
      edit_hour   <= '0;
      edit_min    <= '0;
      edit_sec    <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      setting_o   <= 1'b0;
      load_o      <= 1'b0;
      load_hour_o <= '0;
      load_min_o  <= '0;
      load_sec_o  <= '0;
      {d8, d7, d6, d5, d4, d3, d2, d1} <= '0;
    end else begin
      state     <= state_nx;
      prev_inc  <= inc_i;
      prev_dec  <= dec_i;
      prev_mode <= mode_i;
      edit_hour <= hour_nx;
      edit_min  <= min_nx;
      edit_sec  <= sec_nx;
      setting_o <= (state_nx != RUN);
      load_o    <= commit;
      if (commit) begin
        load_hour_o <= edit_hour;
        load_min_o  <= edit_min;
        load_sec_o  <= edit_sec;
      end
      // Any state change or accepted edit restarts the blink with the field visible
      if ((state_nx != state) || edit_ok) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (state != RUN) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      d8 <= digit_byte(tens(src_hour),  hide_h);
      d7 <= digit_byte(units(src_hour), hide_h);
      d6 <= 8'h00;
      d5 <= digit_byte(tens(src_min),   hide_m);
      d4 <= digit_byte(units(src_min),  hide_m);
      d3 <= 8'h00;
      d2 <= digit_byte(tens(src_sec),   hide_s);
      d1 <= digit_byte(units(src_sec),  hide_s);
    end
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Time-setting controller and display formatter for the Nexys A7 digital clock. It consumes the debounced increment, decrement and config button levels and the running hh:mm:ss from the time counter. It drives the eight digit bytes d1..d8 into dspl_drv_NexysA7. In setting mode it edits a private copy of the time and commits it to the counter through a one-cycle load interface.

Parameters:
BLINK_DIV, 25_000_000, clock cycles per blink half-period (2 Hz blink at 100 MHz); must be >= 2

Ports:
clk_100MHz_i  in   1  system clock, 100 MHz
reset_i       in   1  synchronous reset, active-low
inc_i         in   1  debounced increment button level, active-high
dec_i         in   1  debounced decrement button level, active-high
mode_i        in   1  debounced config button level, active-high
run_sec_i     in   6  running seconds from counter
run_min_i     in   6  running minutes from counter
run_hour_i    in   5  running hours from counter
setting_o     out  1  high while in any SET state; counter freezes while high
load_o        out  1  one-cycle commit pulse to counter
load_sec_o    out  6  committed seconds, valid with load_o
load_min_o    out  6  committed minutes, valid with load_o
load_hour_o   out  5  committed hours, valid with load_o
d1..d8        out  8 each  digit bytes to display driver

Behaviour:
- One clock (clk_100MHz_i). reset_i is synchronous and active-low; all registers reset on the rising edge while reset_i=0.
- Reset values:
  - state=RUN; all outputs 0, so d1..d8=8'h00 (all digits dark).
  - edit regs=0; blink counter=0, phase=visible.
  - Previous-level regs for all three buttons=1, so a button held through reset yields no edge.
- Edge detect: rise_x = x_i & ~prev_x; prev_x is updated every cycle.
- FSM states: RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing only on rise_mode.
- RUN -> SET_H:
  - edit regs load run_* in the same edge.
  - Out-of-range inputs saturate: hour >23 -> 23, min/sec >59 -> 59.
- SET_S -> RUN:
  - load_o=1 for exactly the next cycle.
  - load_* = edit regs, held until the next commit.
- Edits, SET states only:
  - rise_inc adds 1 to the selected field; rise_dec subtracts 1.
  - Hours wrap 23<->0; minutes and seconds wrap 59<->0.
  - rise_inc and rise_dec in the same cycle: no change.
  - rise_mode in the same cycle as inc/dec: mode wins; the edit is dropped.
  - inc/dec are ignored in RUN.
- setting_o is registered; it is 1 in the cycle after entering SET_H and 0 in the cycle after returning to RUN.
- Blink:
  - Counter counts 0..BLINK_DIV-1 only in SET states; phase toggles at terminal count.
  - Counter cleared and phase forced visible on every state entry and on every accepted edit.
  - In blink-off phase, both digits of the selected field output 8'h00.
- Digit byte format: {en, 2'b00, bcd[3:0], dp}.
  - en=1 for shown digits; dp=0 always.
  - tens = value/10, units = value%10, computed combinationally.
- Layout: d8,d7 = hour tens/units; d6=8'h00; d5,d4 = minute tens/units; d3=8'h00; d2,d1 = second tens/units.
- Display source: run_* in RUN, edit regs in SET states.
- d1..d8 are registered, with 1-cycle latency from source change.
- Reset mid-setting: return to RUN with no load_o pulse; edits are discarded.

Test Plan:
- Reset and display:
  - Stimulus: hold reset_i=0 for 3 cycles with run=12:34:56.
  - During reset: d1..d8=0, load_o=0, setting_o=0.
  - 2 cycles after release: d8=0x82, d7=0x84, d6=0x00, d5=0x86, d4=0x88, d3=0x00, d2=0x8A, d1=0x8C.
- Enter set and hour wrap:
  - Stimulus: run=23:59:58, pulse mode, then pulse inc.
  - Required: setting_o=1; edit hour 23->0; d8=0x80, d7=0x80.
- Minute/second edits:
  - Stimulus: in SET_M with min=0, pulse dec; then mode; then inc and dec rising in the same cycle.
  - Required: min=59 (d5=0x8A, d4=0x92); second unchanged.
- Commit:
  - Stimulus: full mode cycle from run=10:20:30 with hour +1, min -1, sec +2.
  - Required: single load_o pulse one cycle after the 4th mode edge, with load=11:19:32; setting_o=0 the following cycle.
- Blink (BLINK_DIV=4):
  - In SET_H: d8/d7 alternate visible/0x00 every 4 cycles; other digits are steady.
  - An inc edge during the off phase makes the digits visible the next cycle and restarts the 4-cycle count.
- Reset and held buttons:
  - Stimulus: reset during SET_M.
  - Required: RUN, no load_o pulse. inc held high across reset release causes no edit and no edge.
  - Stimulus: mode+inc rising together in SET_H.
  - Required: advance to SET_M; hour unchanged.
